// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, then a sign-fix cycle that commits HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiVal,
  output logic [WIDTH-1:0] LoVal
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, acc_s, prod_s;
  logic [WIDTH-1:0]     dvs_r, hi_r, lo_r, hi_s, lo_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s, rem_sub_s;
  logic [WIDTH:0]       sum_s, sh_s;
  logic                 is_div_r, neg_lo_r, neg_hi_r, busy_r, done_r;
  logic                 start_md_s, a_neg_s, b_neg_s, b_zero_s, ge_s;

  assign start_md_s = Start & (state_r == IDLE) & ~Op[2];
  assign a_neg_s    = ~Op[0] & OpA[WIDTH-1];
  assign b_neg_s    = ~Op[0] & OpB[WIDTH-1];
  assign mag_a_s    = a_neg_s ? -OpA : OpA;
  assign mag_b_s    = b_neg_s ? -OpB : OpB;
  assign b_zero_s   = (OpB == {WIDTH{1'b0}});

  assign Busy  = busy_r;
  assign Done  = done_r;
  assign HiVal = hi_r;
  assign LoVal = lo_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_md_s) state_s = CALC;
        else            state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == LAST_CNT) state_s = FIX;
        else                   state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration step and the sign-corrected results committed in FIX
  always_comb begin
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
    sh_s      = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    ge_s      = (sh_s >= {1'b0, dvs_r});
    // Partial remainder stays below the divisor, so the W-bit difference is exact
    rem_sub_s = sh_s[WIDTH-1:0] - dvs_r;
    acc_s     = {sum_s, acc_r[WIDTH-1:1]};
    prod_s    = neg_lo_r ? -acc_r : acc_r;
    hi_s      = prod_s[2*WIDTH-1:WIDTH];
    lo_s      = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (ge_s) acc_s = {rem_sub_s, acc_r[WIDTH-2:0], 1'b1};
      else      acc_s = {sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      lo_s = neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
      hi_s = neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      acc_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start_md_s) begin
            acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
            dvs_r    <= mag_b_s;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= Op[1];
            // Divide by zero keeps an all-ones quotient; remainder negation restores raw OpA
            neg_lo_r <= (a_neg_s ^ b_neg_s) & ~(Op[1] & b_zero_s);
            neg_hi_r <= a_neg_s & Op[1];
          end else if (Start && (Op == 3'b100)) begin
            hi_r <= OpA;
          end else if (Start && (Op == 3'b101)) begin
            lo_r <= OpA;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          acc_r <= acc_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          hi_r <= hi_s;
          lo_r <= lo_s;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, a cycle-level
// reference model built on plain integer arithmetic, and per-cycle comparison.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, Start;
  logic [2:0]  Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done;
  logic [31:0] HiVal, LoVal;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] m_res;
  int          m_cnt;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .HiVal(HiVal), .LoVal(LoVal)
  );

  // Architectural result {HI, LO} of a mult/div from integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Reference model: fixed 33-edge latency, MTHI/MTLO immediate, Start ignored while busy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_res <= 64'd0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_busy <= 1'b0; m_done <= 1'b1;
        end
      end else if (Start) begin
        case (Op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            m_res <= ref_result(Op, OpA, OpB); m_cnt <= 33; m_busy <= 1'b1;
          end
          3'd4: m_hi <= OpA;
          3'd5: m_lo <= OpA;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(Busy), 32'(m_busy));
      chk("cyc_done", 32'(Done), 32'(m_done));
      chk("cyc_hi", HiVal, m_hi);
      chk("cyc_lo", LoVal, m_lo);
    end
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit inj, input logic [31:0] pre_hi);
    int cyc, bcnt;
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(negedge clk);
    Start = 1'b0; Op = 3'b111; OpA = ~a; OpB = ~b;
    cyc  = 1;
    bcnt = Busy ? 1 : 0;
    while (!Done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (Busy) bcnt++;
      if (inj && cyc == 5) begin
        Start = 1'b1; Op = 3'b100; OpA = 32'hDEADBEEF;
      end else if (inj && cyc == 6) begin
        Start = 1'b0; Op = 3'b111;
      end else if (inj && cyc == 8) begin
        chk({nm, "_hi_held"}, HiVal, pre_hi);
      end
    end
    chk({nm, "_done"}, 32'(Done), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd33);
    chk({nm, "_hi"}, HiVal, ehi);
    chk({nm, "_lo"}, LoVal, elo);
    chk({nm, "_model_hi"}, m_hi, ehi);
    chk({nm, "_model_lo"}, m_lo, elo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; Start = 1'b0; Op = 3'b111; OpA = 32'd0; OpB = 32'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_hi", HiVal, 32'd0);
    chk("rst_lo", LoVal, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ops: each Start lands in the cycle Done is high
    do_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32'd0);
    do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 32'hFFFFFFFF);
    do_op("mult_m1",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32'd0);
    do_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'd0);
    do_op("divu",      3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32'd0);
    do_op("divu_z",    3'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b0, 32'd0);
    do_op("div_z",     3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 32'd0);
    do_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32'd0);
    @(negedge clk);

    Start = 1'b1; Op = 3'd4; OpA = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", HiVal, 32'h12345678);
    chk("mthi_busy", 32'(Busy), 32'd0);
    Op = 3'd5; OpA = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo_lo", LoVal, 32'h9ABCDEF0);
    chk("mtlo_hi", HiVal, 32'h12345678);
    chk("mtlo_done", 32'(Done), 32'd0);
    Op = 3'd6; OpA = 32'h0;
    @(negedge clk);
    chk("noop_hi", HiVal, 32'h12345678);
    chk("noop_lo", LoVal, 32'h9ABCDEF0);
    Start = 1'b0; Op = 3'b111;
    @(negedge clk);

    // Abort a multiply mid-calculation with an asynchronous reset
    Start = 1'b1; Op = 3'd0; OpA = 32'd6; OpB = 32'd7;
    @(negedge clk);
    Start = 1'b0; Op = 3'b111;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_hi", HiVal, 32'd0);
    chk("abort_lo", LoVal, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("mult_67", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit on the execute path, directly downstream of the register file.
- Consumes the two register read values (Rs, Rt operands) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers that MFHI/MFLO read.
- Multi-cycle; the control path stalls on Busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  operation request, sampled on rising clk.
- Op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- OpA  input  WIDTH  Rs value: multiplicand, dividend, or MTHI/MTLO data.
- OpB  input  WIDTH  Rt value: multiplier or divisor.
- Busy  output  1  high while a mult/div is in progress.
- Done  output  1  one-cycle pulse when HI/LO are updated by a mult/div.
- HiVal  output  WIDTH  current HI register.
- LoVal  output  WIDTH  current LO register.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State IDLE; Busy=0, Done=0, HI=0, LO=0, counter=0, internal operand regs 0.
  - Takes effect immediately, including mid-operation; the aborted operation leaves no trace.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start=1 with Op in {MULT, MULTU, DIV, DIVU}: latch the operands. Signed ops latch magnitudes plus sign flags (result sign = signA xor signB; remainder sign = signA). Clear the counter, go to CALC.
  - Start=1 with Op=MTHI: HI<=OpA at that edge; stay IDLE. Op=MTLO: LO<=OpA likewise. Busy and Done are not asserted for MTHI/MTLO.
  - Op 11x: no effect.
- CALC: one radix-2 step per cycle for exactly WIDTH cycles.
  - Multiply: shift-add producing a 2*WIDTH-bit unsigned product.
  - Divide: restoring shift-subtract producing an unsigned quotient and remainder.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX (one cycle):
  - Negate results per the sign flags (two's complement, modulo 2^WIDTH).
  - Multiply: HI <= upper half, LO <= lower half.
  - Divide: LO <= quotient, HI <= remainder.
  - Return to IDLE. Done=1 in the cycle following the FIX edge.
- Timing: Start accepted at edge E0. Busy=1 after E0 until the FIX edge E(WIDTH+1). HI/LO are updated and Done is high in the cycle after E(WIDTH+1), i.e. latency 33 cycles for WIDTH=32. The same latency applies to every mult/div, including divide-by-zero.
- Busy is registered: 1 in CALC and FIX, 0 in IDLE. Done is registered and high for exactly one cycle.
- Start while Busy=1 (any Op, including MTHI/MTLO) is ignored. The controller holds the instruction until Busy=0.
- Start in the same cycle Done is high is accepted normally (state is already IDLE).
- HiVal/LoVal are continuous register outputs. During Busy they hold their pre-operation values and only change at the FIX edge.
- Divide by zero (OpB=0), signed or unsigned: LO=all ones, HI=OpA (raw, unsigned-interpreted dividend). No exception.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Operand inputs are sampled only at the Start edge; later changes to OpA/OpB have no effect on the running operation.

Test Plan:
- Reset, then MULT OpA=0xFFFFFFFD (-3), OpB=5 -> Busy high for 33 cycles, Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Also MULT with the same operands -> HI=0, LO=1.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- Corner divides:
  - DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x64.
  - DIV 0xFFFFFFF9/0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> HiVal/LoVal update one edge after each Start, Busy and Done stay 0. Start MTHI while Busy -> HI unchanged.
- Start MULT 6x7, drop rst_n at cycle 10 of CALC -> Busy=0 and HI=LO=0 immediately, no Done. After release, MULT 6x7 -> LO=42, HI=0 after 33 cycles.
